nibble_serial_addsub_ctrl: RTL and testbench
============================================

NIBBLE_SERIAL_ADDSUB_CTRL -- requirements
Module: nibble_serial_addsub_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Ports (name direction width meaning) SHALL be exactly:
  clk      input   1   rising-edge clock
  rst_n    input   1   asynchronous active-low reset
  start    input   1   request; sampled only when ready=1
  op_sub   input   1   0=A+B, 1=A-B; captured with start
  a        input   16  operand A; captured with start
  b        input   16  operand B; captured with start
  ready    output  1   1 = IDLE, start will be accepted
  busy     output  1   1 while nibbles are being processed
  done     output  1   one-cycle completion pulse
  result   output  16  sum/difference, held until next accepted start
  carry    output  1   carry out of bit 15 (sub: 1 = no borrow)
  ovf      output  1   two's-complement signed overflow
REQ-003 No parameters; the word width SHALL be fixed at 16 bits, processed as four 4-bit nibbles.

Function
REQ-004 The block SHALL contain one 4-bit ripple add/sub slice of four full adders: s[3:0],c4 = an + (bn XOR {4{op}}) + cin.
REQ-005 The FSM SHALL have states IDLE, RUN and DONE, plus a 2-bit nibble index idx.
REQ-006 In IDLE with start=1 at a rising edge, the block SHALL capture a, b and op_sub, set idx=0, set the carry register to op_sub, clear result, and enter RUN.
REQ-007 In RUN, each edge SHALL apply nibble idx of the captured operands to the slice, write s into result[4*idx+3:4*idx], load c4 into the carry register, and increment idx.
REQ-008 On the RUN edge with idx=3, the block SHALL also set ovf = (carry into bit 15) XOR c4 and enter DONE.
REQ-009 DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-010 Latency: if start is accepted at the end of cycle 0, busy SHALL be 1 in cycles 1-4, done SHALL be 1 in cycle 5, and ready SHALL be 1 again in cycle 6.
REQ-011 Outputs SHALL be registered or decoded from state only: ready=(IDLE), busy=(RUN), done=(DONE).
REQ-012 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change when a, b or op_sub change mid-operation.
REQ-013 result, carry and ovf SHALL be valid from the done cycle onward and SHALL hold until the next accepted start.
REQ-014 Arithmetic SHALL be modulo 2^16 with no saturation; subtraction SHALL be computed as A + ~B + 1.
REQ-015 Back-to-back operation: start held high continuously SHALL produce one operation every 6 cycles.

Reset
REQ-016 While rst_n=0, independent of clk, the block SHALL force state=IDLE, idx=0, result=0x0000, carry=0, ovf=0, done=0, busy=0 and ready=1.
REQ-017 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-018 Add: a=0x1234, b=0x0FFF, op_sub=0 -> done in cycle 5 with result=0x2233, carry=0, ovf=0.
REQ-019 Carry and signed overflow: 0xFFFF+0x0001 -> 0x0000, carry=1, ovf=0; 0x7FFF+0x0001 -> 0x8000, carry=0, ovf=1.
REQ-020 Subtract: 0x0005-0x0007 -> 0xFFFE, carry=0, ovf=0; 0x8000-0x0001 -> 0x7FFF, carry=1, ovf=1.
REQ-021 Ignored start: start a new operation in cycle 2 with different operands -> first result unaffected, exactly one done pulse, ready=0 during cycles 1-5.
REQ-022 Reset mid-operation: rst_n low in cycle 3 -> outputs immediately at reset values, no done pulse, next start gives the correct result.
REQ-023 The bench SHALL run a random scoreboard of at least 1000 operations against a 17-bit reference model checking result, carry and ovf.

Source files
------------

// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial 16-bit adder/subtractor.
// One 4-bit ripple slice is reused for four cycles, low nibble first.
module nibble_serial_addsub_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry,
    output logic        ovf
);

    localparam int unsigned W  = 16;
    localparam int unsigned NW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            op_q;
    logic [1:0]      idx;
    logic [NW-1:0]   an;
    logic [NW-1:0]   bx;
    logic [NW-1:0]   s;
    logic [NW:0]     c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (idx == 2'd3) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded directly from the state.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_IDLE:  ready = 1'b1;
            S_RUN:   busy  = 1'b1;
            S_DONE:  done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // 4-bit ripple slice of four full adders; B is inverted for subtraction.
    always_comb begin
        an   = NW'(a_q >> (NW * 32'(idx)));
        bx   = NW'(b_q >> (NW * 32'(idx))) ^ {NW{op_q}};
        c    = '0;
        s    = '0;
        c[0] = carry;
        for (int i = 0; i < int'(NW); i++) begin
            s[i]   = an[i] ^ bx[i] ^ c[i];
            c[i+1] = (an[i] & bx[i]) | (c[i] & (an[i] ^ bx[i]));
        end
    end

    // Operand capture and per-nibble result/carry update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 1'b0;
            idx    <= 2'd0;
            result <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        op_q   <= op_sub;
                        idx    <= 2'd0;
                        carry  <= op_sub;
                        result <= '0;
                        ovf    <= 1'b0;
                    end
                end
                S_RUN: begin
                    result[NW*32'(idx) +: NW] <= s;
                    carry <= c[NW];
                    idx   <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        ovf <= c[NW-1] ^ c[NW];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed and random self-checking bench for nibble_serial_addsub_ctrl.
module tb_nibble_serial_addsub_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    nibble_serial_addsub_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 17-bit reference: sign-rule overflow, independent of any carry chain.
    task automatic ref_model(input logic [15:0] x, input logic [15:0] y, input logic o,
                             output logic [15:0] r, output logic c, output logic v);
        logic [16:0] t;
        if (o) t = {1'b0, x} + {1'b0, ~y} + 17'd1;
        else   t = {1'b0, x} + {1'b0, y};
        r = t[15:0];
        c = t[16];
        if (o) v = (x[15] != y[15]) && (r[15] != x[15]);
        else   v = (x[15] == y[15]) && (r[15] != x[15]);
    endtask

    // One full operation from an IDLE cycle, checking every cycle up to cycle 6.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic top, input logic [15:0] er, input logic ec, input logic ev);
        check({tag, ".ready0"}, 32'(ready), 32'd1);
        a = ta; b = tb; op_sub = top; start = 1'b1;
        step();
        start = 1'b0; a = ~ta; b = ~tb; op_sub = ~top;
        for (int k = 1; k <= 4; k++) begin
            check({tag, ".busy"}, 32'(busy), 32'd1);
            check({tag, ".ready_run"}, 32'(ready), 32'd0);
            check({tag, ".done_run"}, 32'(done), 32'd0);
            step();
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".busy5"}, 32'(busy), 32'd0);
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".carry"}, 32'(carry), 32'(ec));
        check({tag, ".ovf"}, 32'(ovf), 32'(ev));
        step();
        check({tag, ".ready6"}, 32'(ready), 32'd1);
        check({tag, ".done6"}, 32'(done), 32'd0);
        check({tag, ".hold"}, 32'({result, carry, ovf}), 32'({er, ec, ev}));
    endtask

    initial begin
        logic [15:0] ra, rb, rr;
        logic        ro, rc, rv;
        int          ndone;
        int          first_done;
        int          second_done;

        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        #1;
        check("rst.ready", 32'(ready), 32'd1);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.outs", 32'({result, carry, ovf}), 32'd0);
        step(); step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("subovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Start re-asserted mid-operation must be ignored.
        a = 16'h1111; b = 16'h2222; op_sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc == 2) begin
                start = 1'b1; a = 16'hABCD; b = 16'h0F0F; op_sub = 1'b1;
            end
            if (cyc == 5) start = 1'b0;
            if (done) ndone++;
            if (cyc <= 5) check("ign.ready", 32'(ready), 32'd0);
            if (cyc == 5) check("ign.result", 32'({result, carry, ovf}), 32'({16'h3333, 1'b0, 1'b0}));
            if (cyc >= 6) check("ign.idle", 32'(ready), 32'd1);
            step();
        end
        check("ign.ndone", 32'(ndone), 32'd1);

        // Reset in cycle 3 aborts the operation.
        a = 16'hFFFF; b = 16'hFFFF; op_sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        check("midrst.ready", 32'(ready), 32'd1);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.outs", 32'({result, carry, ovf}), 32'd0);
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (done) ndone++;
        end
        check("midrst.nodone", 32'(ndone), 32'd0);
        run_op("postrst", 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Start held high: one operation every 6 cycles.
        a = 16'h00FF; b = 16'h0001; op_sub = 1'b0; start = 1'b1;
        step();
        first_done = 0; second_done = 0; ndone = 0;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) first_done = cyc;
                if (ndone == 2) second_done = cyc;
                check("b2b.result", 32'(result), 32'h0100);
            end
            step();
        end
        start = 1'b0;
        check("b2b.first", 32'(first_done), 32'd5);
        check("b2b.second", 32'(second_done), 32'd11);
        check("b2b.count", 32'(ndone), 32'd2);
        for (int k = 0; k < 8; k++) step();

        // Random scoreboard against the reference model.
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ro = 1'($urandom_range(0, 1));
            ref_model(ra, rb, ro, rr, rc, rv);
            run_op("rand", ra, rb, ro, rr, rc, rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
